// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg
//   Shared definitions for the ALU issue stage: data width, opcode
//   encodings, the last legal opcode and the issue FSM state type.
//   No ports; imported by alu_issue_stage and alu_issue_stage_regfile.
package alu_issue_stage_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1010;
  localparam logic [3:0] OP_PASS = 4'b1011;

  // Any opcode above this one is reported as illegal.
  localparam logic [3:0] OP_LAST_LEGAL = OP_PASS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2
  } state_t;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// alu_issue_stage_regfile
//   2**REG_AW x DATA_W register file, one write port, three combinational
//   read ports. Register 0 always reads as zero and ignores writes.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset (clears all entries)
//     we, waddr, wdata write port
//     raddr1/rdata1   read port 1 (source 1)
//     raddr2/rdata2   read port 2 (source 2)
//     raddr3/rdata3   read port 3 (debug)
module alu_issue_stage_regfile
  import alu_issue_stage_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [REG_AW-1:0] raddr3,
  output logic [DATA_W-1:0] rdata3
);

  localparam int DEPTH = 2 ** REG_AW;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads are plain combinational lookups: a write committed on an edge is
  // visible in the following cycle, which is all the issue FSM needs.
  assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];
  assign rdata3 = (raddr3 == '0) ? '0 : mem[raddr3];

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Single-issue ALU front end: accepts one instruction, reads its operands
//   from the register file, drives an external combinational ALU for one
//   cycle, captures the result and writes it back. One instruction per
//   three cycles (IDLE -> ISSUE -> WB).
//   Optional macro: ALU_ISSUE_FLAGS_EN enables zero/overflow status flags;
//   when undefined both flags are tied to 0.
//   Ports:
//     clk, rst                     clock, asynchronous active-high reset
//     in_valid/in_ready            instruction handshake
//     in_opcode, in_rd, in_rs1, in_rs2, in_use_imm, in_imm  instruction fields
//     alu_a, alu_b, alu_opcode     operands/opcode to the ALU (held registers)
//     alu_en                       ALU enable, high only in ISSUE for legal ops
//     alu_res                      ALU result, sampled at the end of ISSUE
//     wb_done                      one-cycle pulse after a legal write-back
//     illegal_op                   one-cycle pulse after an illegal opcode
//     zero_flag, ovf_flag          registered status flags
//     dbg_addr, dbg_data           combinational register-file read port
//
//   Handshake: an instruction transfers on a rising edge where in_valid and
//   in_ready are both high. in_ready depends only on FSM state (high only in
//   IDLE), never on in_valid; the offering side must hold the fields stable
//   while in_valid is high and in_ready is low.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_use_imm,
  input  logic [31:0]       in_imm,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [3:0]        alu_opcode,
  output logic              alu_en,
  input  logic [31:0]       alu_res,
  output logic              wb_done,
  output logic              illegal_op,
  output logic              zero_flag,
  output logic              ovf_flag,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);

  state_t              state;
  logic [REG_AW-1:0]   rd_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [3:0]          op_q;
  logic [DATA_W-1:0]   res_q;
  logic [DATA_W-1:0]   rs1_data;
  logic [DATA_W-1:0]   rs2_data;
  logic                legal;
  logic                wr_en;

  assign legal    = is_legal(op_q);
  assign in_ready = (state == ST_IDLE);
  assign alu_en   = (state == ST_ISSUE) && legal;
  assign wr_en    = (state == ST_WB) && legal;

  // Operand/opcode registers drive the ALU directly so they hold their
  // last values outside ISSUE.
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;

  alu_issue_stage_regfile #(
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wr_en),
    .waddr  (rd_q),
    .wdata  (res_q),
    .raddr1 (in_rs1),
    .rdata1 (rs1_data),
    .raddr2 (in_rs2),
    .rdata2 (rs2_data),
    .raddr3 (dbg_addr),
    .rdata3 (dbg_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      res_q      <= '0;
      wb_done    <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      // Pulses are registered off the WB state, so they appear in the cycle
      // after WB, together with the register write becoming visible.
      wb_done    <= (state == ST_WB) && legal;
      illegal_op <= (state == ST_WB) && !legal;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q  <= in_opcode;
            rd_q  <= in_rd;
            a_q   <= rs1_data;
            b_q   <= in_use_imm ? in_imm : rs2_data;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          res_q <= alu_res;
          state <= ST_WB;
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_FLAGS_EN
  logic [DATA_W:0] sum_ext;
  logic [DATA_W:0] dif_ext;

  // Carry/borrow out of the 33-bit unsigned sum/difference of the latched
  // operands, independent of what the external ALU computed.
  assign sum_ext = {1'b0, a_q} + {1'b0, b_q};
  assign dif_ext = {1'b0, a_q} - {1'b0, b_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_flag <= 1'b0;
      ovf_flag  <= 1'b0;
    end else if (wr_en) begin
      zero_flag <= (res_q == '0);
      case (op_q)
        OP_ADD:  ovf_flag <= sum_ext[DATA_W];
        OP_SUB:  ovf_flag <= dif_ext[DATA_W];
        default: ovf_flag <= 1'b0;
      endcase
    end
  end
`else
  assign zero_flag = 1'b0;
  assign ovf_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [3:0]  in_rd;
  logic [3:0]  in_rs1;
  logic [3:0]  in_rs2;
  logic        in_use_imm;
  logic [31:0] in_imm;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_opcode;
  logic        alu_en;
  logic [31:0] alu_res;
  logic        wb_done;
  logic        illegal_op;
  logic        zero_flag;
  logic        ovf_flag;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks;
  int errors;

  alu_issue_stage #(.REG_AW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_use_imm (in_use_imm),
    .in_imm     (in_imm),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_en     (alu_en),
    .alu_res    (alu_res),
    .wb_done    (wb_done),
    .illegal_op (illegal_op),
    .zero_flag  (zero_flag),
    .ovf_flag   (ovf_flag),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU for the opcodes the vectors use.
  always_comb begin
    alu_res = 32'h0;
    case (alu_opcode)
      4'b0000: alu_res = alu_a + alu_b;
      4'b0001: alu_res = alu_a - alu_b;
      4'b0100: alu_res = alu_a ^ alu_b;
      4'b1011: alu_res = alu_b;
      default: alu_res = 32'h0;
    endcase
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic        use_imm;
    logic [31:0] imm;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_ill;
    logic        exp_zf;
    logic        exp_of;
    logic [31:0] exp_rd_val;
  } vec_t;

  vec_t vecs [9];

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 10) begin
      tick();
      n++;
    end
    check("wait_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  // Driver + checker for one instruction; starts #1 after an edge.
  task automatic run_vec(input int idx, input vec_t v);
    logic zf_exp;
    logic of_exp;
`ifdef ALU_ISSUE_FLAGS_EN
    zf_exp = v.exp_zf;
    of_exp = v.exp_of;
`else
    zf_exp = 1'b0;
    of_exp = 1'b0;
`endif
    wait_ready();
    in_valid   = 1'b1;
    in_opcode  = v.op;
    in_rd      = v.rd;
    in_rs1     = v.rs1;
    in_rs2     = v.rs2;
    in_use_imm = v.use_imm;
    in_imm     = v.imm;
    tick();                                   // edge N: accepted -> ISSUE
    in_valid = 1'b0;
    check($sformatf("v%0d_issue_ready", idx), {31'b0, in_ready}, 32'd0);
    check($sformatf("v%0d_issue_en", idx), {31'b0, alu_en}, {31'b0, !v.exp_ill});
    check($sformatf("v%0d_alu_a", idx), alu_a, v.exp_a);
    check($sformatf("v%0d_alu_b", idx), alu_b, v.exp_b);
    check($sformatf("v%0d_alu_op", idx), {28'b0, alu_opcode}, {28'b0, v.op});
    tick();                                   // edge N+1: -> WB
    check($sformatf("v%0d_wb_ready", idx), {31'b0, in_ready}, 32'd0);
    check($sformatf("v%0d_wb_en", idx), {31'b0, alu_en}, 32'd0);
    check($sformatf("v%0d_wb_hold_a", idx), alu_a, v.exp_a);
    check($sformatf("v%0d_wb_early_done", idx), {31'b0, wb_done}, 32'd0);
    tick();                                   // edge N+2: write-back done
    dbg_addr = v.rd;
    #1;
    check($sformatf("v%0d_done_ready", idx), {31'b0, in_ready}, 32'd1);
    check($sformatf("v%0d_wb_done", idx), {31'b0, wb_done}, {31'b0, !v.exp_ill});
    check($sformatf("v%0d_illegal", idx), {31'b0, illegal_op}, {31'b0, v.exp_ill});
    check($sformatf("v%0d_zero", idx), {31'b0, zero_flag}, {31'b0, zf_exp});
    check($sformatf("v%0d_ovf", idx), {31'b0, ovf_flag}, {31'b0, of_exp});
    check($sformatf("v%0d_dbg_rd", idx), dbg_data, v.exp_rd_val);
  endtask

  // ---------------- test ----------------
  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_opcode  = 4'h0;
    in_rd      = 4'h0;
    in_rs1     = 4'h0;
    in_rs2     = 4'h0;
    in_use_imm = 1'b0;
    in_imm     = 32'h0;
    dbg_addr   = 4'h1;

    //               op     rd   rs1  rs2  imm? imm           a             b             ill  zf   of   rd value
    vecs[0] = '{4'h0, 4'd1, 4'd0, 4'd0, 1'b1, 32'd5,        32'd0,        32'd5,        1'b0, 1'b0, 1'b0, 32'd5};
    vecs[1] = '{4'h0, 4'd2, 4'd1, 4'd1, 1'b0, 32'd0,        32'd5,        32'd5,        1'b0, 1'b0, 1'b0, 32'd10};
    vecs[2] = '{4'hB, 4'd3, 4'd0, 4'd0, 1'b1, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF};
    vecs[3] = '{4'h0, 4'd5, 4'd3, 4'd0, 1'b1, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0, 1'b1, 1'b1, 32'd0};
    vecs[4] = '{4'h1, 4'd6, 4'd0, 4'd0, 1'b1, 32'd1,        32'd0,        32'd1,        1'b0, 1'b0, 1'b1, 32'hFFFFFFFF};
    vecs[5] = '{4'hC, 4'd2, 4'd1, 4'd0, 1'b1, 32'd99,       32'd5,        32'd99,       1'b1, 1'b0, 1'b1, 32'd10};
    vecs[6] = '{4'h0, 4'd0, 4'd0, 4'd0, 1'b1, 32'd7,        32'd0,        32'd7,        1'b0, 1'b0, 1'b0, 32'd0};
    vecs[7] = '{4'h4, 4'd7, 4'd2, 4'd0, 1'b1, 32'h0000000F, 32'd10,       32'd15,       1'b0, 1'b0, 1'b0, 32'd5};
    vecs[8] = '{4'h1, 4'd8, 4'd2, 4'd1, 1'b0, 32'd0,        32'd10,       32'd5,        1'b0, 1'b0, 1'b0, 32'd5};

    // Reset state, sampled while rst is still high.
    repeat (3) tick();
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_alu_en", {31'b0, alu_en}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_op", {28'b0, alu_opcode}, 32'd0);
    check("rst_wb_done", {31'b0, wb_done}, 32'd0);
    check("rst_illegal", {31'b0, illegal_op}, 32'd0);
    check("rst_flags", {30'b0, zero_flag, ovf_flag}, 32'd0);
    check("rst_dbg_r1", dbg_data, 32'd0);
    rst = 1'b0;
    tick();

    // Back-to-back: each vector is offered the cycle it completes.
    for (int i = 0; i < 9; i++) begin
      run_vec(i, vecs[i]);
    end

    // Illegal vector must not have touched r1 (its source) or r3.
    dbg_addr = 4'd3;
    #1;
    check("r3_kept", dbg_data, 32'hFFFFFFFF);

    // Reset during ISSUE of r4 = imm 9 aborts the instruction.
    wait_ready();
    in_valid   = 1'b1;
    in_opcode  = 4'hB;
    in_rd      = 4'd4;
    in_rs1     = 4'd0;
    in_use_imm = 1'b1;
    in_imm     = 32'd9;
    tick();
    in_valid = 1'b0;
    check("abort_in_issue", {31'b0, alu_en}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_rst_alu_en", {31'b0, alu_en}, 32'd0);
    check("abort_rst_alu_b", alu_b, 32'd0);
    check("abort_rst_ready", {31'b0, in_ready}, 32'd1);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("abort_wb_done_c%0d", k), {31'b0, wb_done}, 32'd0);
      check($sformatf("abort_ready_c%0d", k), {31'b0, in_ready}, 32'd1);
    end
    dbg_addr = 4'd4;
    #1;
    check("abort_r4", dbg_data, 32'd0);
    dbg_addr = 4'd2;
    #1;
    check("abort_r2_cleared", dbg_data, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
